// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the PC, probes a direct-mapped one-word-per-line
// instruction cache, and on a miss assembles the word little-endian from four
// byte reads on the memory-controller port. Redirects from EX abort any fetch.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          ENTRIES  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  stall,
    input  logic        branch_flag,
    input  logic [31:0] branch_target,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [7:0]  mem_rdata,
    output logic        stall_req_if,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_valid
);

    localparam int IDX  = $clog2(ENTRIES);
    localparam int TAGW = 30 - IDX;

    typedef enum logic [1:0] {
        S_LOOKUP = 2'd0,
        S_FETCH  = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [1:0]  k_q, k_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_inst_q, if_inst_d;
    logic        if_valid_q, if_valid_d;

    // Cache storage: valid bits are reset, tag/data are not
    logic [ENTRIES-1:0] valid_q;
    logic [TAGW-1:0]    tag_q  [ENTRIES];
    logic [31:0]        data_q [ENTRIES];

    logic [IDX-1:0]  idx;
    logic [TAGW-1:0] pc_tag;
    logic            hit;
    logic            cache_we;
    logic [31:0]     cache_wdata;
    logic [31:0]     word_done;
    logic            deliver;
    logic [31:0]     deliver_word;

    // Stall bits 4..2 belong to later stages; low target bits are forced to zero
    logic unused_inputs;
    assign unused_inputs = ^{stall[4:2], branch_target[1:0]};

    assign idx    = pc_q[IDX+1:2];
    assign pc_tag = pc_q[31:IDX+2];
    assign hit    = valid_q[idx] && (tag_q[idx] == pc_tag);

    // The byte arriving now completes the word on top of the three buffered ones
    assign word_done = {mem_rdata, buf_q[23:0]};

    assign mem_req  = (state_q == S_FETCH);
    assign mem_addr = pc_q + {30'd0, k_q};

    // Stall request never looks at the stall vector, so no loop through the controller
    assign stall_req_if = rst
                        || ((state_q == S_LOOKUP) && !hit)
                        || (state_q == S_FETCH);

    assign if_pc    = if_pc_q;
    assign if_inst  = if_inst_q;
    assign if_valid = if_valid_q;

    // Next-state, output-register and cache-write decisions
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        k_d          = k_q;
        buf_d        = buf_q;
        if_pc_d      = if_pc_q;
        if_inst_d    = if_inst_q;
        if_valid_d   = if_valid_q;
        cache_we     = 1'b0;
        cache_wdata  = word_done;
        deliver      = 1'b0;
        deliver_word = word_done;

        case (state_q)
            S_LOOKUP: begin
                if (hit) begin
                    if (!stall[1]) begin
                        deliver      = 1'b1;
                        deliver_word = data_q[idx];
                    end
                end else begin
                    if (!stall[1]) begin
                        if_valid_d = 1'b0;
                    end
                    state_d = S_FETCH;
                    k_d     = 2'd0;
                end
            end
            S_FETCH: begin
                if (!stall[1]) begin
                    if_valid_d = 1'b0;
                end
                if (mem_ready) begin
                    buf_d[{k_q, 3'b000} +: 8] = mem_rdata;
                    k_d                       = k_q + 2'd1;
                    if (k_q == 2'd3) begin
                        cache_we = 1'b1;
                        if (!stall[1]) begin
                            deliver      = 1'b1;
                            deliver_word = word_done;
                            state_d      = S_LOOKUP;
                        end else begin
                            buf_d   = word_done;
                            state_d = S_HOLD;
                        end
                    end
                end
            end
            S_HOLD: begin
                if (!stall[1]) begin
                    deliver      = 1'b1;
                    deliver_word = buf_q;
                    state_d      = S_LOOKUP;
                end
            end
            default: begin
                state_d = S_LOOKUP;
                k_d     = 2'd0;
            end
        endcase

        if (deliver) begin
            if_inst_d  = deliver_word;
            if_pc_d    = pc_q;
            if_valid_d = 1'b1;
            if (!stall[0]) begin
                pc_d = pc_q + 32'd4;
            end
        end

        // A redirect overrides everything, including a byte accepted this edge
        if (branch_flag) begin
            pc_d       = {branch_target[31:2], 2'b00};
            if_valid_d = 1'b0;
            if_inst_d  = if_inst_q;
            if_pc_d    = if_pc_q;
            state_d    = S_LOOKUP;
            k_d        = 2'd0;
            cache_we   = 1'b0;
        end
    end

    // Pipeline and FSM state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_LOOKUP;
            pc_q       <= RESET_PC;
            k_q        <= 2'd0;
            buf_q      <= 32'd0;
            if_pc_q    <= 32'd0;
            if_inst_q  <= 32'd0;
            if_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            k_q        <= k_d;
            buf_q      <= buf_d;
            if_pc_q    <= if_pc_d;
            if_inst_q  <= if_inst_d;
            if_valid_q <= if_valid_d;
        end
    end

    // Per-line valid bits, cleared by reset so the cache starts cold
    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_valid
            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_q[gi] <= 1'b0;
                end else if (cache_we && (idx == gi[IDX-1:0])) begin
                    valid_q[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    // Tag and data arrays are only written when a fill completes
    always_ff @(posedge clk) begin
        if (!rst && cache_we) begin
            tag_q[idx]  <= pc_tag;
            data_q[idx] <= cache_wdata;
        end
    end

endmodule
